// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet controller: state encoding and default
// iteration and settle parameters used by the top-level integration.
package maxnet_pkg;

  localparam int MAXNET_MAX_ITER      = 32;
  localparam int MAXNET_SETTLE_CYCLES = 1;
  localparam int MAXNET_ITER_W        = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_INIT  = 3'd2,
    ST_MULT  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ADD   = 3'd5,
    ST_CHECK = 3'd6,
    ST_FEED  = 3'd7
  } state_e;

  // DONE shares no spare code in 3 bits, so it is carried as a separate flag.
  typedef struct packed {
    state_e st;
    logic   done;
  } fsm_state_t;

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with a zero flag; sets how long the FSM waits for
// the floating-point add/activation path to settle.
module settle_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer for the MaxNet winner-take-all datapath: load, inhibition
// iterations until the datapath reports a single survivor, then done/timeout.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int MAX_ITER      = MAXNET_MAX_ITER,
  parameter int SETTLE_CYCLES = MAXNET_SETTLE_CYCLES,
  parameter int ITER_W        = MAXNET_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              found,
  output logic              mainRegWrite,
  output logic              actWrite,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              multWrite,
  output logic              addWrite,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  fsm_state_t        state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              timeout_q, timeout_d;
  logic              main_reg_write_q, main_reg_write_d;
  logic              act_write_q, act_write_d;
  logic              sel_q, sel_d;
  logic              mult_write_q, mult_write_d;
  logic              add_write_q, add_write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              settle_zero;
  logic              settle_load;

  assign settle_load = !state_q.done && (state_q.st == ST_MULT);

  settle_counter #(
    .W(CNT_W)
  ) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .zero     (settle_zero)
  );

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    if (state_q.done) begin
      state_d = '{st: ST_IDLE, done: 1'b0};
    end else begin
      unique case (state_q.st)
        ST_IDLE: begin
          if (start) begin
            state_d.st = ST_LOAD;
            iter_d     = '0;
            timeout_d  = 1'b0;
          end
        end
        ST_LOAD:  state_d.st = ST_INIT;
        ST_INIT:  state_d.st = ST_MULT;
        ST_MULT:  state_d.st = ST_WAIT;
        ST_WAIT: begin
          if (settle_zero) state_d.st = ST_ADD;
        end
        ST_ADD: begin
          state_d.st = ST_CHECK;
          if (iter_q != '1) iter_d = iter_q + ITER_W'(1);
        end
        ST_CHECK: begin
          // found is only trusted here, after the b registers have been updated.
          if (found) begin
            state_d   = '{st: ST_IDLE, done: 1'b1};
            timeout_d = 1'b0;
          end else if (iter_q == ITER_W'(MAX_ITER)) begin
            state_d   = '{st: ST_IDLE, done: 1'b1};
            timeout_d = 1'b1;
          end else begin
            state_d.st = ST_FEED;
            timeout_d  = 1'b0;
          end
        end
        ST_FEED:  state_d.st = ST_MULT;
        default:  state_d.st = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    main_reg_write_d = !state_d.done && (state_d.st == ST_LOAD);
    act_write_d      = !state_d.done && ((state_d.st == ST_INIT) || (state_d.st == ST_FEED));
    sel_d            = !state_d.done && (state_d.st == ST_FEED);
    mult_write_d     = !state_d.done && (state_d.st == ST_MULT);
    add_write_d      = !state_d.done && (state_d.st == ST_ADD);
    busy_d           = state_d.done || (state_d.st != ST_IDLE);
    done_d           = state_d.done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= '{st: ST_IDLE, done: 1'b0};
      iter_q           <= '0;
      timeout_q        <= 1'b0;
      main_reg_write_q <= 1'b0;
      act_write_q      <= 1'b0;
      sel_q            <= 1'b0;
      mult_write_q     <= 1'b0;
      add_write_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      iter_q           <= iter_d;
      timeout_q        <= timeout_d;
      main_reg_write_q <= main_reg_write_d;
      act_write_q      <= act_write_d;
      sel_q            <= sel_d;
      mult_write_q     <= mult_write_d;
      add_write_q      <= add_write_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign mainRegWrite = main_reg_write_q;
  assign actWrite     = act_write_q;
  assign s1           = sel_q;
  assign s2           = sel_q;
  assign s3           = sel_q;
  assign s4           = sel_q;
  assign multWrite    = mult_write_q;
  assign addWrite     = add_write_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: a MAX_ITER=4/SETTLE=1 instance driven
// by a scripted found flag, plus a MAX_ITER=1/SETTLE=3 instance for the limits.
module tb_maxnet_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start = 1'b0, found = 1'b0;
  logic       mrw, aw, s1, s2, s3, s4, mw, adw, busy, done, timeout;
  logic [5:0] iter_count;

  logic       start_b = 1'b0, found_b = 1'b0;
  logic       mrw_b, aw_b, s1_b, s2_b, s3_b, s4_b, mw_b, adw_b, busy_b, done_b, timeout_b;
  logic [5:0] iter_b;

  logic [10:0] outv;
  assign outv = {mrw, aw, s1, s2, s3, s4, mw, adw, busy, done, timeout};

  int total = 0;
  int bad   = 0;

  // results of the last run() call
  int r_edge, r_feeds, r_adds, r_sel_err, r_to, r_iter, r_first_to;

  always #5 clk = ~clk;

  maxnet_controller #(.MAX_ITER(4), .SETTLE_CYCLES(1), .ITER_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .found(found),
    .mainRegWrite(mrw), .actWrite(aw), .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .multWrite(mw), .addWrite(adw), .busy(busy), .done(done),
    .timeout(timeout), .iter_count(iter_count)
  );

  maxnet_controller #(.MAX_ITER(1), .SETTLE_CYCLES(3), .ITER_W(6)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .found(found_b),
    .mainRegWrite(mrw_b), .actWrite(aw_b), .s1(s1_b), .s2(s2_b), .s3(s3_b), .s4(s4_b),
    .multWrite(mw_b), .addWrite(adw_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .iter_count(iter_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode: 0 found never, 1 found always, 2 found only during ADD,
  //       3 found in the CHECK cycle of iteration 2. Stops at the first done.
  task automatic run(input int mode, input bit hold, input int poke);
    bit prev_add = 1'b0;
    r_edge = -1; r_feeds = 0; r_adds = 0; r_sel_err = 0; r_to = -1; r_iter = -1; r_first_to = -1;
    @(negedge clk);
    start = 1'b1;
    found = (mode == 1);
    for (int e = 0; e < 80; e++) begin
      @(negedge clk);
      start = hold || (e == poke);
      if (e == 0) r_first_to = int'(timeout);
      if (s1) r_feeds++;
      if (s2 !== s1 || s3 !== s1 || s4 !== s1) r_sel_err++;
      if (adw) r_adds++;
      case (mode)
        0:       found = 1'b0;
        1:       found = 1'b1;
        2:       found = adw;
        default: found = prev_add && (r_adds == 2);
      endcase
      prev_add = adw;
      if (done) begin
        r_edge = e;
        r_to   = int'(timeout);
        r_iter = int'(iter_count);
        break;
      end
    end
    found = 1'b0;
    $display("run mode=%0d done_edge=%0d feeds=%0d adds=%0d timeout=%0d iter=%0d",
             mode, r_edge, r_feeds, r_adds, r_to, r_iter);
  endtask

  task automatic run_b(input bit f);
    int ed = -1, to = -1, it = -1;
    @(negedge clk);
    start_b = 1'b1;
    found_b = f;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin
        ed = e; to = int'(timeout_b); it = int'(iter_b);
        break;
      end
    end
    found_b = 1'b0;
    $display("run_b found=%0d done_edge=%0d timeout=%0d iter=%0d", f, ed, to, it);
    chk($sformatf("b_f%0d_edge", f), 32'(ed), 32'd8);
    chk($sformatf("b_f%0d_timeout", f), 32'(to), f ? 32'd0 : 32'd1);
    chk($sformatf("b_f%0d_iter", f), 32'(it), 32'd1);
  endtask

  logic [10:0] trace_exp [8] = '{
    11'b10000000100,  // LOAD
    11'b01000000100,  // INIT
    11'b00000010100,  // MULT
    11'b00000000100,  // WAIT
    11'b00000001100,  // ADD
    11'b00000000100,  // CHECK
    11'b00000000110,  // DONE
    11'b00000000000   // IDLE
  };

  initial begin
    int idle_busy;

    #1 chk("reset_outputs", 32'(outv), 32'd0);
    chk("reset_iter", 32'(iter_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset mid-WAIT
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_wait_busy", 32'(outv), 32'b00000000100);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", 32'(outv), 32'd0);
    chk("async_reset_iter", 32'(iter_count), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 32'(outv), 32'd0);

    // Single-iteration run, cycle-by-cycle trace
    @(negedge clk); start = 1'b1; found = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("trace_e%0d", e), 32'(outv), 32'(trace_exp[e]));
      if (e >= 5) chk($sformatf("trace_iter_e%0d", e), 32'(iter_count), 32'd1);
    end
    found = 1'b0;

    // Never found: timeout after 4 iterations
    run(0, 1'b0, -1);
    chk("to_edge", 32'(r_edge), 32'd21);
    chk("to_feeds", 32'(r_feeds), 32'd3);
    chk("to_adds", 32'(r_adds), 32'd4);
    chk("to_sel_equal", 32'(r_sel_err), 32'd0);
    chk("to_timeout", 32'(r_to), 32'd1);
    chk("to_iter", 32'(r_iter), 32'd4);
    @(negedge clk);
    chk("to_held_idle", 32'(outv), 32'b00000000001);

    // Next start clears timeout; stray start during MULT is ignored
    run(1, 1'b0, 2);
    chk("clear_timeout_first", 32'(r_first_to), 32'd0);
    chk("poke_edge", 32'(r_edge), 32'd6);
    chk("poke_timeout", 32'(r_to), 32'd0);
    idle_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || done) idle_busy++;
    end
    chk("poke_single_done", 32'(idle_busy), 32'd0);

    // found glitching only during ADD must not end the run
    run(2, 1'b0, -1);
    chk("glitch_edge", 32'(r_edge), 32'd21);
    chk("glitch_timeout", 32'(r_to), 32'd1);

    // found on the second iteration
    run(3, 1'b0, -1);
    chk("iter2_edge", 32'(r_edge), 32'd11);
    chk("iter2_timeout", 32'(r_to), 32'd0);
    chk("iter2_iter", 32'(r_iter), 32'd2);
    chk("iter2_feeds", 32'(r_feeds), 32'd1);
    @(negedge clk);

    // start held through DONE restarts from IDLE
    run(1, 1'b1, -1);
    chk("hold_edge", 32'(r_edge), 32'd6);
    @(negedge clk);
    chk("hold_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("hold_restart_load", 32'(outv), 32'b10000000100);
    #2 rst = 1'b0;
    #1 chk("hold_reset_outputs", 32'(outv), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // MAX_ITER=1, SETTLE_CYCLES=3 instance
    run_b(1'b0);
    run_b(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
